// File: rtl/mic_tdoa_ctrl.sv
// mic_tdoa_ctrl: time-difference-of-arrival sequencer for a left/right microphone pair.
//
// The block arms on a start pulse and waits for the first falling edge on either
// microphone. It then counts cycles until the other channel falls, or until TIMEOUT.
// The outcome is published through a valid/ack handshake, with irq mirroring
// result_valid. After the ack, the block ignores the microphones for HOLDOFF cycles
// to reject echoes. It then returns to IDLE, or re-arms when cfg_auto_rearm is set.
//
// Ports:
//   HCLK, HRESETn        clock, asynchronous active-low reset
//   microphone_left/right raw asynchronous sensor inputs, idle high, active-low pulse
//   start                arm request (IDLE only)
//   abort                return to IDLE from any state and clear the result
//   cfg_auto_rearm       after holdoff: 1 -> ARMED, 0 -> IDLE
//   result_ack           consumer acknowledge of the current result (DONE only)
//   busy                 high in every state except IDLE
//   result_valid, irq    result registers valid
//   direction            01 left first, 10 right first, 11 simultaneous, 00 none
//   delta_cnt            cycles between first and second edge detection
//   timeout              second channel never arrived
module mic_tdoa_ctrl #(
    parameter int unsigned CNT_W   = 17,
    parameter int unsigned TIMEOUT = 100000,
    parameter int unsigned HOLDOFF = 10000
) (
    input  logic             HCLK,
    input  logic             HRESETn,
    input  logic             microphone_left,
    input  logic             microphone_right,
    input  logic             start,
    input  logic             abort,
    input  logic             cfg_auto_rearm,
    input  logic             result_ack,
    output logic             busy,
    output logic             result_valid,
    output logic [1:0]       direction,
    output logic [CNT_W-1:0] delta_cnt,
    output logic             timeout,
    output logic             irq
);

    localparam int unsigned HOLD_W = (HOLDOFF < 2) ? 1 : $clog2(HOLDOFF + 1);
    localparam logic [CNT_W-1:0]  TimeoutVal = CNT_W'(TIMEOUT);
    localparam logic [HOLD_W-1:0] HoldoffVal = HOLD_W'(HOLDOFF);
    localparam logic [CNT_W-1:0]  CntMax     = {CNT_W{1'b1}};

    typedef enum logic [2:0] {
        StIdle,
        StArmed,
        StWait,
        StDone,
        StHoldoff
    } state_e;

    // ------------------------------------------------------------------
    // Input synchronizers plus history flop. The synchronizers are preset
    // high so that reset release does not fake an edge. Both channels see
    // identical latency, so the measured delta is unaffected.
    // ------------------------------------------------------------------
    logic l_sync1_q, l_sync2_q, l_hist_q;
    logic r_sync1_q, r_sync2_q, r_hist_q;
    logic fall_l, fall_r;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            l_sync1_q <= 1'b1;
            l_sync2_q <= 1'b1;
            l_hist_q  <= 1'b1;
            r_sync1_q <= 1'b1;
            r_sync2_q <= 1'b1;
            r_hist_q  <= 1'b1;
        end else begin
            l_sync1_q <= microphone_left;
            l_sync2_q <= l_sync1_q;
            l_hist_q  <= l_sync2_q;
            r_sync1_q <= microphone_right;
            r_sync2_q <= r_sync1_q;
            r_hist_q  <= r_sync2_q;
        end
    end

    assign fall_l = l_hist_q & ~l_sync2_q;
    assign fall_r = r_hist_q & ~r_sync2_q;

    // ------------------------------------------------------------------
    // Sequencer. All outputs are registered here.
    // ------------------------------------------------------------------
    state_e            state_q;
    logic              first_right_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [HOLD_W-1:0] hold_q;
    logic              second_fall;

    // The edge that completes the measurement is the channel that did not start it.
    assign second_fall = first_right_q ? fall_l : fall_r;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q       <= StIdle;
            first_right_q <= 1'b0;
            cnt_q         <= '0;
            hold_q        <= '0;
            busy          <= 1'b0;
            result_valid  <= 1'b0;
            irq           <= 1'b0;
            direction     <= 2'b00;
            delta_cnt     <= '0;
            timeout       <= 1'b0;
        end else if (abort) begin
            // Abort overrides everything else and wipes the published result.
            state_q       <= StIdle;
            first_right_q <= 1'b0;
            cnt_q         <= '0;
            hold_q        <= '0;
            busy          <= 1'b0;
            result_valid  <= 1'b0;
            irq           <= 1'b0;
            direction     <= 2'b00;
            delta_cnt     <= '0;
            timeout       <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q <= StArmed;
                        busy    <= 1'b1;
                    end
                end

                StArmed: begin
                    if (fall_l && fall_r) begin
                        state_q      <= StDone;
                        result_valid <= 1'b1;
                        irq          <= 1'b1;
                        direction    <= 2'b11;
                        delta_cnt    <= '0;
                        timeout      <= 1'b0;
                    end else if (fall_l) begin
                        state_q       <= StWait;
                        first_right_q <= 1'b0;
                        cnt_q         <= CNT_W'(1);
                    end else if (fall_r) begin
                        state_q       <= StWait;
                        first_right_q <= 1'b1;
                        cnt_q         <= CNT_W'(1);
                    end
                end

                StWait: begin
                    // The second-channel edge is checked first, so it wins over a
                    // timeout in the same cycle.
                    if (second_fall) begin
                        state_q      <= StDone;
                        result_valid <= 1'b1;
                        irq          <= 1'b1;
                        direction    <= first_right_q ? 2'b10 : 2'b01;
                        delta_cnt    <= cnt_q;
                        timeout      <= 1'b0;
                    end else if (cnt_q == TimeoutVal) begin
                        state_q      <= StDone;
                        result_valid <= 1'b1;
                        irq          <= 1'b1;
                        direction    <= first_right_q ? 2'b10 : 2'b01;
                        delta_cnt    <= TimeoutVal;
                        timeout      <= 1'b1;
                    end else if (cnt_q != CntMax) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end

                StDone: begin
                    if (result_ack) begin
                        state_q      <= StHoldoff;
                        result_valid <= 1'b0;
                        irq          <= 1'b0;
                        hold_q       <= HOLD_W'(1);
                    end
                end

                StHoldoff: begin
                    // hold_q counts the holdoff cycles spent so far, starting at 1.
                    if (hold_q == HoldoffVal) begin
                        if (cfg_auto_rearm) begin
                            state_q <= StArmed;
                        end else begin
                            state_q <= StIdle;
                            busy    <= 1'b0;
                        end
                    end else begin
                        hold_q <= hold_q + HOLD_W'(1);
                    end
                end

                default: begin
                    state_q <= StIdle;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mic_tdoa_ctrl.sv
// Self-checking bench for mic_tdoa_ctrl. Directed steps and randomized pairs are
// compared against a rule-level model of the expected measurement result.
module tb_mic_tdoa_ctrl;

    localparam int unsigned CNT_W   = 10;
    localparam int unsigned TIMEOUT = 600;
    localparam int unsigned HOLDOFF = 40;

    logic             HCLK;
    logic             HRESETn;
    logic             microphone_left;
    logic             microphone_right;
    logic             start;
    logic             abort;
    logic             cfg_auto_rearm;
    logic             result_ack;
    logic             busy;
    logic             result_valid;
    logic [1:0]       direction;
    logic [CNT_W-1:0] delta_cnt;
    logic             timeout;
    logic             irq;

    int checks   = 0;
    int failures = 0;

    mic_tdoa_ctrl #(
        .CNT_W  (CNT_W),
        .TIMEOUT(TIMEOUT),
        .HOLDOFF(HOLDOFF)
    ) dut (
        .HCLK            (HCLK),
        .HRESETn         (HRESETn),
        .microphone_left (microphone_left),
        .microphone_right(microphone_right),
        .start           (start),
        .abort           (abort),
        .cfg_auto_rearm  (cfg_auto_rearm),
        .result_ack      (result_ack),
        .busy            (busy),
        .result_valid    (result_valid),
        .direction       (direction),
        .delta_cnt       (delta_cnt),
        .timeout         (timeout),
        .irq             (irq)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge HCLK);
    endtask

    task automatic pins_high();
        microphone_left  = 1'b1;
        microphone_right = 1'b1;
        tick(4);
    endtask

    task automatic arm();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic wait_valid(input int budget);
        int n = 0;
        while (result_valid !== 1'b1 && n < budget) begin
            tick(1);
            n++;
        end
        check("valid_arrives", 32'(result_valid), 32'd1);
    endtask

    // Acknowledge, release the pins and let the holdoff expire into IDLE.
    task automatic ack_to_idle();
        cfg_auto_rearm   = 1'b0;
        result_ack       = 1'b1;
        tick(1);
        result_ack       = 1'b0;
        microphone_left  = 1'b1;
        microphone_right = 1'b1;
        tick(HOLDOFF + 3);
    endtask

    // Expected result from the arrival gap (in cycles) of the second channel.
    task automatic model(input bit first_right, input int gap,
                         output logic [1:0] dir, output int delta, output logic to);
        if (gap == 0) begin
            dir = 2'b11; delta = 0; to = 1'b0;
        end else if (gap <= int'(TIMEOUT)) begin
            dir = first_right ? 2'b10 : 2'b01; delta = gap; to = 1'b0;
        end else begin
            dir = first_right ? 2'b10 : 2'b01; delta = int'(TIMEOUT); to = 1'b1;
        end
    endtask

    // Pins must be high and the block armed. First channel falls now, the other
    // channel `gap` cycles later; the result is then compared with the model.
    task automatic run_pair(input string tag, input bit first_right, input int gap);
        logic [1:0] e_dir;
        int         e_delta;
        logic       e_to;
        model(first_right, gap, e_dir, e_delta, e_to);
        if (gap == 0) begin
            microphone_left  = 1'b0;
            microphone_right = 1'b0;
        end else begin
            if (first_right) microphone_right = 1'b0;
            else             microphone_left  = 1'b0;
            for (int i = 1; i <= gap; i++) begin
                tick(1);
                if (i == gap) begin
                    if (first_right) microphone_left  = 1'b0;
                    else             microphone_right = 1'b0;
                end
            end
        end
        wait_valid(10);
        check({tag, "_dir"},   32'(direction), 32'(e_dir));
        check({tag, "_delta"}, 32'(delta_cnt), 32'(e_delta));
        check({tag, "_to"},    32'(timeout),   32'(e_to));
        check({tag, "_irq"},   32'(irq),       32'd1);
    endtask

    initial begin
        logic [1:0]       s_dir;
        logic [CNT_W-1:0] s_delta;
        bit               stable;

        HRESETn          = 1'b0;
        microphone_left  = 1'b1;
        microphone_right = 1'b1;
        start            = 1'b0;
        abort            = 1'b0;
        cfg_auto_rearm   = 1'b0;
        result_ack       = 1'b0;
        tick(3);
        HRESETn = 1'b1;
        tick(2);

        // Reset state
        check("rst_busy",  32'(busy),         32'd0);
        check("rst_valid", 32'(result_valid), 32'd0);
        check("rst_dir",   32'(direction),    32'd0);
        check("rst_delta", 32'(delta_cnt),    32'd0);
        check("rst_to",    32'(timeout),      32'd0);
        check("rst_irq",   32'(irq),          32'd0);

        // Left first, right 40 cycles later
        arm();
        check("arm_busy", 32'(busy), 32'd1);
        run_pair("t1", 1'b0, 40);
        check("t1_busy", 32'(busy), 32'd1);

        // Result held while unacknowledged
        s_dir   = direction;
        s_delta = delta_cnt;
        stable  = 1'b1;
        for (int i = 0; i < 500; i++) begin
            tick(1);
            if (result_valid !== 1'b1 || direction !== s_dir || delta_cnt !== s_delta ||
                timeout !== 1'b0 || irq !== 1'b1) stable = 1'b0;
        end
        check("hold_stable", 32'(stable), 32'd1);

        // Ack drops valid next cycle; edges during holdoff are ignored; IDLE after HOLDOFF
        result_ack = 1'b1;
        tick(1);
        result_ack = 1'b0;
        check("ack_valid", 32'(result_valid), 32'd0);
        check("ack_irq",   32'(irq),          32'd0);
        microphone_left  = 1'b1;
        microphone_right = 1'b1;
        tick(4);
        microphone_left = 1'b0;
        tick(5);
        microphone_right = 1'b0;
        tick(5);
        microphone_left  = 1'b1;
        microphone_right = 1'b1;
        tick(HOLDOFF - 15);
        check("hold_busy_end",  32'(busy),         32'd1);
        check("hold_no_result", 32'(result_valid), 32'd0);
        tick(1);
        check("hold_idle_busy", 32'(busy),         32'd0);
        check("hold_idle_dir",  32'(direction),    32'd1);
        check("hold_idle_dlt",  32'(delta_cnt),    32'd40);

        // Right first with right re-falls in WAIT, left pulsing thereafter
        arm();
        microphone_right = 1'b0;
        tick(2);
        microphone_right = 1'b1;
        tick(2);
        microphone_right = 1'b0;
        tick(3);
        microphone_left = 1'b0;
        tick(20);
        check("t2_dir",   32'(direction), 32'd2);
        check("t2_delta", 32'(delta_cnt), 32'd7);
        microphone_left = 1'b1;
        tick(10);
        microphone_left = 1'b0;
        tick(15);
        microphone_left = 1'b1;
        tick(10);
        microphone_left = 1'b0;
        tick(30);
        check("t2_dir_held",   32'(direction), 32'd2);
        check("t2_delta_held", 32'(delta_cnt), 32'd7);

        // Auto re-arm: busy stays up and the next pair is measured without start
        cfg_auto_rearm = 1'b1;
        result_ack     = 1'b1;
        tick(1);
        result_ack = 1'b0;
        pins_high();
        tick(HOLDOFF);
        check("rearm_busy",  32'(busy),         32'd1);
        check("rearm_valid", 32'(result_valid), 32'd0);
        cfg_auto_rearm = 1'b0;
        run_pair("rearm", 1'b0, 25);
        ack_to_idle();

        // Simultaneous edges
        arm();
        microphone_left  = 1'b0;
        microphone_right = 1'b0;
        tick(2);
        check("t3_early", 32'(result_valid), 32'd0);
        tick(1);
        check("t3_valid", 32'(result_valid), 32'd1);
        check("t3_dir",   32'(direction),    32'd3);
        check("t3_delta", 32'(delta_cnt),    32'd0);
        ack_to_idle();

        // Timeout with exact latency
        arm();
        microphone_left = 1'b0;
        tick(TIMEOUT + 2);
        check("t4_early", 32'(result_valid), 32'd0);
        tick(1);
        check("t4_valid", 32'(result_valid), 32'd1);
        check("t4_to",    32'(timeout),      32'd1);
        check("t4_dir",   32'(direction),    32'd1);
        check("t4_delta", 32'(delta_cnt),    32'(TIMEOUT));
        ack_to_idle();

        // Edge on cnt==TIMEOUT wins; one cycle later times out
        arm();
        run_pair("t4b", 1'b0, int'(TIMEOUT));
        ack_to_idle();
        arm();
        run_pair("t4c", 1'b1, int'(TIMEOUT) + 1);
        ack_to_idle();

        // Randomized pairs
        for (int t = 0; t < 8; t++) begin
            bit fr;
            int gap;
            fr = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0:       gap = int'($urandom_range(0, 3));
                1:       gap = int'($urandom_range(1, TIMEOUT));
                2:       gap = int'($urandom_range(TIMEOUT - 2, TIMEOUT + 2));
                default: gap = int'($urandom_range(TIMEOUT + 1, TIMEOUT + 30));
            endcase
            arm();
            run_pair($sformatf("rnd%0d", t), fr, gap);
            ack_to_idle();
        end

        // Start while busy has no effect on the measurement
        arm();
        microphone_left = 1'b0;
        tick(5);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(24);
        microphone_right = 1'b0;
        wait_valid(10);
        check("busy_start_delta", 32'(delta_cnt), 32'd30);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        check("busy_start_valid", 32'(result_valid), 32'd1);
        ack_to_idle();

        // Abort mid-WAIT clears everything
        arm();
        microphone_left = 1'b0;
        tick(500);
        check("abort_pre_busy", 32'(busy), 32'd1);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        check("abort_busy",  32'(busy),         32'd0);
        check("abort_valid", 32'(result_valid), 32'd0);
        check("abort_dir",   32'(direction),    32'd0);
        check("abort_delta", 32'(delta_cnt),    32'd0);
        check("abort_to",    32'(timeout),      32'd0);
        check("abort_irq",   32'(irq),          32'd0);
        microphone_right = 1'b0;
        tick(10);
        check("abort_no_result", 32'(result_valid), 32'd0);
        pins_high();

        // Abort while DONE clears the published result
        arm();
        run_pair("pre_abort", 1'b1, 12);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        check("abort_done_valid", 32'(result_valid), 32'd0);
        check("abort_done_dir",   32'(direction),    32'd0);
        pins_high();

        // Asynchronous reset mid-WAIT, after a non-zero result
        arm();
        run_pair("pre_rst", 1'b0, 9);
        ack_to_idle();
        arm();
        microphone_right = 1'b0;
        tick(100);
        #2;
        HRESETn = 1'b0;
        #1;
        check("arst_busy",  32'(busy),         32'd0);
        check("arst_valid", 32'(result_valid), 32'd0);
        check("arst_dir",   32'(direction),    32'd0);
        check("arst_delta", 32'(delta_cnt),    32'd0);
        tick(2);
        HRESETn = 1'b1;
        pins_high();
        check("arst_after_busy", 32'(busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
